// File: rtl/multicycle_sequencer_if.sv
// ============================================================================
// multicycle_sequencer_if : memory handshake and datapath control bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface multicycle_sequencer_if #(
    parameter int RETIRE_W = 32
);
    logic [6:0]          opcode;
    logic                branch_taken;
    logic                imem_req;
    logic                imem_ready;
    logic                dmem_req;
    logic                dmem_we;
    logic                dmem_ready;
    logic                ir_we;
    logic                pc_we;
    logic                next_pc_src;
    logic                alu_a_src;
    logic                alu_b_src;
    logic [1:0]          rud_src;
    logic                ru_wr;
    logic [2:0]          state;
    logic                trap;
    logic [1:0]          trap_cause;
    logic [RETIRE_W-1:0] retired;

    // Sequencer side
    modport master (
        input  opcode, branch_taken, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, next_pc_src,
               alu_a_src, alu_b_src, rud_src, ru_wr, state, trap,
               trap_cause, retired
    );

    // Datapath / memory side
    modport slave (
        output opcode, branch_taken, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, next_pc_src,
               alu_a_src, alu_b_src, rud_src, ru_wr, state, trap,
               trap_cause, retired
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// multicycle_sequencer : FETCH/DECODE/EXEC/MEM/WB control for RV32I datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_sequencer #(
    parameter int TIMEOUT  = 16,
    parameter int RETIRE_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    multicycle_sequencer_if.master ctrl
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        CL_R      = 4'd0,
        CL_I      = 4'd1,
        CL_LOAD   = 4'd2,
        CL_STORE  = 4'd3,
        CL_BRANCH = 4'd4,
        CL_JAL    = 4'd5,
        CL_JALR   = 4'd6,
        CL_LUI    = 4'd7,
        CL_AUIPC  = 4'd8,
        CL_ILL    = 4'd9
    } class_e;

    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [1:0]        CAUSE_ILL  = 2'b01;
    localparam logic [1:0]        CAUSE_IMEM = 2'b10;
    localparam logic [1:0]        CAUSE_DMEM = 2'b11;
    localparam logic [1:0]        RUD_ALU    = 2'b00;
    localparam logic [1:0]        RUD_MEM    = 2'b01;
    localparam logic [1:0]        RUD_PC4    = 2'b10;

    function automatic class_e decode_op(input logic [6:0] op);
        case (op)
            7'b0110011: decode_op = CL_R;
            7'b0010011: decode_op = CL_I;
            7'b0000011: decode_op = CL_LOAD;
            7'b0100011: decode_op = CL_STORE;
            7'b1100011: decode_op = CL_BRANCH;
            7'b1101111: decode_op = CL_JAL;
            7'b1100111: decode_op = CL_JALR;
            7'b0110111: decode_op = CL_LUI;
            7'b0010111: decode_op = CL_AUIPC;
            default:    decode_op = CL_ILL;
        endcase
    endfunction

    state_e              state_q, state_d;
    class_e              class_q, class_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                trap_q, trap_d;
    logic [1:0]          cause_q, cause_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;

    logic       w_sel_a;
    logic       w_sel_b;
    logic       w_timeout;
    logic       w_imem_req;
    logic       w_ir_we;
    logic       w_dmem_req;
    logic       w_dmem_we;
    logic       w_pc_we;
    logic       w_next_pc_src;
    logic       w_alu_a_src;
    logic       w_alu_b_src;
    logic [1:0] w_rud_src;
    logic       w_ru_wr;

    // ALU operand selects for the latched class, shared by EXEC, MEM and link WB
    always_comb begin
        w_sel_a = 1'b0;
        w_sel_b = 1'b1;
        case (class_q)
            CL_R:                         w_sel_b = 1'b0;
            CL_AUIPC, CL_JAL, CL_BRANCH:  w_sel_a = 1'b1;
            default:                      ;
        endcase
    end

    assign w_timeout = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

    always_comb begin
        state_d       = state_q;
        class_d       = class_q;
        wait_d        = '0;
        trap_d        = trap_q;
        cause_d       = cause_q;
        w_imem_req    = 1'b0;
        w_ir_we       = 1'b0;
        w_dmem_req    = 1'b0;
        w_dmem_we     = 1'b0;
        w_pc_we       = 1'b0;
        w_next_pc_src = 1'b0;
        w_alu_a_src   = 1'b0;
        w_alu_b_src   = 1'b0;
        w_rud_src     = RUD_ALU;
        w_ru_wr       = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (ctrl.imem_ready) begin
                    w_ir_we = 1'b1;
                    state_d = ST_DECODE;
                end else if (w_timeout) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_IMEM;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            ST_DECODE: begin
                class_d = decode_op(ctrl.opcode);
                if (decode_op(ctrl.opcode) == CL_ILL) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILL;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                w_alu_a_src = w_sel_a;
                w_alu_b_src = w_sel_b;
                case (class_q)
                    CL_BRANCH: begin
                        w_pc_we       = 1'b1;
                        w_next_pc_src = ctrl.branch_taken;
                        state_d       = ST_FETCH;
                    end
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    default:           state_d = ST_WB;
                endcase
            end

            ST_MEM: begin
                w_dmem_req  = 1'b1;
                w_dmem_we   = (class_q == CL_STORE);
                w_alu_a_src = w_sel_a;
                w_alu_b_src = w_sel_b;
                if (ctrl.dmem_ready) begin
                    if (class_q == CL_STORE) begin
                        w_pc_we = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (w_timeout) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_DMEM;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            ST_WB: begin
                w_ru_wr = 1'b1;
                w_pc_we = 1'b1;
                state_d = ST_FETCH;
                if (class_q == CL_LOAD) begin
                    w_rud_src = RUD_MEM;
                end else if (class_q == CL_JAL || class_q == CL_JALR) begin
                    // Link writes PC+4 while the ALU recomputes the jump target
                    w_rud_src     = RUD_PC4;
                    w_next_pc_src = 1'b1;
                    w_alu_a_src   = w_sel_a;
                    w_alu_b_src   = w_sel_b;
                end
            end

            ST_TRAP: ;

            default: state_d = ST_FETCH;
        endcase

        if (rst) begin
            w_imem_req    = 1'b0;
            w_ir_we       = 1'b0;
            w_dmem_req    = 1'b0;
            w_dmem_we     = 1'b0;
            w_pc_we       = 1'b0;
            w_next_pc_src = 1'b0;
            w_alu_a_src   = 1'b0;
            w_alu_b_src   = 1'b0;
            w_rud_src     = RUD_ALU;
            w_ru_wr       = 1'b0;
        end

        retired_d = retired_q + RETIRE_W'(w_pc_we);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            class_q   <= CL_R;
            wait_q    <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            wait_q    <= wait_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    assign ctrl.imem_req    = w_imem_req;
    assign ctrl.ir_we       = w_ir_we;
    assign ctrl.dmem_req    = w_dmem_req;
    assign ctrl.dmem_we     = w_dmem_we;
    assign ctrl.pc_we       = w_pc_we;
    assign ctrl.next_pc_src = w_next_pc_src;
    assign ctrl.alu_a_src   = w_alu_a_src;
    assign ctrl.alu_b_src   = w_alu_b_src;
    assign ctrl.rud_src     = w_rud_src;
    assign ctrl.ru_wr       = w_ru_wr;
    assign ctrl.state       = state_q;
    assign ctrl.trap        = trap_q;
    assign ctrl.trap_cause  = cause_q;
    assign ctrl.retired     = retired_q;

endmodule

`default_nettype wire
